serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised, bit-serial WIDTH-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Uses a single registered full-subtractor cell, with the borrow carried between cycles in a flop.
- Successor to the combinational single-bit full subtractor: operand width is generalised, and the block adds a start/busy/done handshake and a signed-overflow flag.
- Used wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk    input   1      single clock, rising edge.
- rst    input   1      asynchronous, active-high reset.
- start  input   1      request; sampled only when busy=0.
- a      input   WIDTH  minuend; sampled on the accepting edge only.
- b      input   WIDTH  subtrahend; sampled on the accepting edge only.
- bin    input   1      borrow-in; sampled on the accepting edge only.
- busy   output  1      high while a subtraction is in progress.
- done   output  1      one-cycle pulse when results update.
- diff   output  WIDTH  result a - b - bin mod 2^WIDTH; held until the next done.
- bout   output  1      borrow out of the MSB; held.
- ovf    output  1      signed (two's complement) overflow; held.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0, borrow flop=0.
  - Any in-flight operation is discarded; no done pulse is produced for it.
- FSM states: IDLE, RUN.
- IDLE:
  - On an edge with start=1: latch a, b and bin into shift registers, counter<=0, state<=RUN, busy<=1.
  - If start=0: remain in IDLE.
- RUN (each edge):
  - Feed a_sh[0], b_sh[0] and the borrow flop into the cell.
  - Cell difference bit shifts into the result register from the MSB side; cell borrow-out -> borrow flop.
  - a_sh and b_sh shift right by one; counter increments.
- Completion, on the edge where counter==WIDTH-1:
  - state<=IDLE, busy<=0, done<=1 for exactly one cycle.
  - diff/bout/ovf update on this edge only.
  - ovf = borrow into the MSB cell XOR borrow out of the MSB cell.
- Latency:
  - Accepting edge E; done is high in the cycle following edge E+WIDTH.
  - busy is high in the cycles following edges E .. E+WIDTH-1.
- start while busy=1 is ignored: no queuing, and latched operands are unaffected.
- start while done=1 (busy=0) is accepted, giving back-to-back operations with a throughput of one result per WIDTH+1 cycles.
- Inputs a, b and bin may change freely while busy.
- The partial result is internal only; diff/bout/ovf never show intermediate values.
- All arithmetic is unsigned modulo 2^WIDTH; bout=1 exactly when a < b + bin (unsigned).

Decomposition:
- Shared package arith_pkg:
  - FSM state typedef (IDLE, RUN).
  - Helper function for the reference result, {bout, diff} = {1'b0, a} - b - bin, used by the bench scoreboard.
- Sub-module fs_cell: combinational 1-bit full subtractor.
  - Inputs x, y, bi; outputs d = x^y^bi, bo = (~x & y) | (~(x^y) & bi).
  - Instantiated once inside serial_subtractor.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0, single start pulse -> busy high for 8 cycles, then done pulse; diff=0x23, bout=0, ovf=0.
- WIDTH=8, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; then a=0x10, b=0x10, bin=1 started in the done cycle -> diff=0xFF, bout=1, ovf=0, done exactly 9 cycles after the first done.
- WIDTH=8 signed overflow cases:
  - a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- WIDTH=8, start a=0x50, b=0x20; pulse start again with a=0xFF, b=0x00 at cycle 3 of RUN -> second start ignored; single done with diff=0x30; no further done.
- WIDTH=8, start a=0xAA, b=0x55; assert rst at cycle 4 of RUN -> busy=0, done=0, diff=0, bout=0, ovf=0 immediately (async); no done pulse after reset release.
- WIDTH=4, exhaustive sweep of all a, b, bin (512 operations) -> every result matches the arith_pkg reference; every done follows its start by exactly 5 edges.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and reference arithmetic for the bit-serial subtractor.
package arith_pkg;

    // Controller states of the serial subtractor.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_e;

    // Reference result: bit [w] of the value is the borrow out of a w-bit
    // subtraction and bits [w-1:0] are the difference, for any w <= 32
    // whose operands are already zero-extended to 32 bits.
    function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        bin);
        return {1'b0, a} - {1'b0, b} - {32'd0, bin};
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, with borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), one bit per clock,
// LSB first, through a single full-subtractor cell. Results are held in
// output registers that update only when an operation completes.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    sub_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic             cell_d;
    logic             cell_bo;

    // The single shared bit cell: current operand LSBs plus the carried borrow.
    fs_cell u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .bi (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Partial result with the new difference bit entering from the MSB side.
    always_comb begin
        // NOTE: assigning a default first means no path leaves res_d unassigned,
        // so no latch can be inferred.
        res_d = res_q;
        res_d = {cell_d, res_q[WIDTH-1:1]};
    end

    // Controller, datapath shift registers and registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
                    res_q    <= res_d;
                    borrow_q <= cell_bo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_MAX) begin
                        // This edge processes the MSB: borrow_q is the borrow
                        // into the sign bit, cell_bo the borrow out of it.
                        diff_q  <= res_d;
                        bout_q  <= cell_bo;
                        ovf_q   <= borrow_q ^ cell_bo;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the scenario
// tests and a 4-bit instance for an exhaustive sweep against arith_pkg.
module tb_serial_subtractor;
    import arith_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    // Present one request to the 8-bit DUT; returns at the negedge after the accepting edge.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Count negedges until done8 (bounded), tallying cycles with busy8 high.
    task automatic wait_done8(output int n, output int busy_cnt);
        n = 0; busy_cnt = 0;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
            n_err++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy8, done8, diff8, bout8, ovf8);
        end
        n_cmp++;
        if ({busy4, done4, diff4, bout4, ovf4} !== 8'h00) begin
            n_err++;
            $display("FAIL reset4: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy4, done4, diff4, bout4, ovf4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int n, bc;
        drive8(8'h35, 8'h12, 1'b0);
        wait_done8(n, bc);
        n_cmp++;
        if (n != 8) begin
            n_err++; $display("FAIL basic_latency: got %0d, want 8", n);
        end
        n_cmp++;
        if (bc != 8) begin
            n_err++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        n_cmp++;
        if ({diff8, bout8, ovf8, busy8} !== {8'h23, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: got diff=%h bout=%b ovf=%b busy=%b, want 23 0 0 0",
                     diff8, bout8, ovf8, busy8);
        end
        @(negedge clk);
        n_cmp++;
        if ({done8, diff8} !== {1'b0, 8'h23}) begin
            n_err++;
            $display("FAIL basic_done_pulse: got done=%b diff=%h, want done=0 diff=23", done8, diff8);
        end
    endtask

    task automatic test_back_to_back;
        int n, bc;
        drive8(8'h00, 8'h01, 1'b0);
        wait_done8(n, bc);
        n_cmp++;
        if ({diff8, bout8, ovf8} !== {8'hFF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_first: got diff=%h bout=%b ovf=%b, want ff 1 0", diff8, bout8, ovf8);
        end
        // Start the second operation in the done cycle of the first.
        drive8(8'h10, 8'h10, 1'b1);
        wait_done8(n, bc);
        n_cmp++;
        if (n + 1 != 9) begin
            n_err++; $display("FAIL b2b_spacing: got %0d, want 9", n + 1);
        end
        n_cmp++;
        if ({diff8, bout8, ovf8} !== {8'hFF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_second: got diff=%h bout=%b ovf=%b, want ff 1 0", diff8, bout8, ovf8);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int n, bc;
        drive8(8'h80, 8'h01, 1'b0);
        wait_done8(n, bc);
        n_cmp++;
        if ({diff8, bout8, ovf8} !== {8'h7F, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_neg: got diff=%h bout=%b ovf=%b, want 7f 0 1", diff8, bout8, ovf8);
        end
        @(negedge clk);
        drive8(8'h7F, 8'hFF, 1'b0);
        wait_done8(n, bc);
        n_cmp++;
        if ({diff8, bout8, ovf8} !== {8'h80, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL ovf_pos: got diff=%h bout=%b ovf=%b, want 80 1 1", diff8, bout8, ovf8);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int n, extra;
        drive8(8'h50, 8'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 3;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != 8) begin
            n_err++; $display("FAIL busy_start_latency: got %0d, want 8", n);
        end
        n_cmp++;
        if ({diff8, bout8, ovf8} !== {8'h30, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL busy_start_result: got diff=%h bout=%b ovf=%b, want 30 0 0", diff8, bout8, ovf8);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++; $display("FAIL busy_start_no_extra: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_mid_reset;
        int active;
        drive8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
                     busy8, done8, diff8, bout8, ovf8);
        end
        @(negedge clk);
        rst = 1'b0;
        active = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) active++;
        end
        n_cmp++;
        if (active != 0) begin
            n_err++; $display("FAIL mid_reset_no_done: got %0d active cycles, want 0", active);
        end
    endtask

    task automatic test_sweep4;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int          n, sa, sb, r;
                    logic [32:0] ref_v;
                    logic [5:0]  exp_v;
                    start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci);
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = ~a4; b4 = ~b4; bin4 = ~bin4;
                    n = 0;
                    while (done4 !== 1'b1 && n < 40) begin
                        @(negedge clk);
                        n++;
                    end
                    sa = (ai >= 8) ? ai - 16 : ai;
                    sb = (bi >= 8) ? bi - 16 : bi;
                    r  = sa - sb - ci;
                    ref_v = ref_sub(32'(ai), 32'(bi), 1'(ci));
                    exp_v = {ref_v[3:0], ref_v[4], (r < -8 || r > 7) ? 1'b1 : 1'b0};
                    n_cmp++;
                    if (n != 4) begin
                        n_err++;
                        $display("FAIL sweep_latency a=%0d b=%0d bin=%0d: got %0d, want 4", ai, bi, ci, n);
                    end
                    n_cmp++;
                    if ({diff4, bout4, ovf4} !== exp_v) begin
                        n_err++;
                        $display("FAIL sweep a=%0d b=%0d bin=%0d: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                                 ai, bi, ci, diff4, bout4, ovf4, exp_v[5:2], exp_v[1], exp_v[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_start_while_busy();
        test_mid_reset();
        test_sweep4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
